// File: rtl/ula_pkg.sv
// Shared opcode, FSM-state and iterative-unit mode encodings for the sequential ULA.
package ula_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_MULT = 4'd2;
    localparam logic [OP_W-1:0] OP_DIV  = 4'd3;
    localparam logic [OP_W-1:0] OP_EQ   = 4'd4;
    localparam logic [OP_W-1:0] OP_GT   = 4'd5;
    localparam logic [OP_W-1:0] OP_LT   = 4'd6;
    localparam logic [OP_W-1:0] OP_NE   = 4'd7;
    localparam logic [OP_W-1:0] OP_AND  = 4'd8;
    localparam logic [OP_W-1:0] OP_NAND = 4'd9;
    localparam logic [OP_W-1:0] OP_OR   = 4'd10;
    localparam logic [OP_W-1:0] OP_NOR  = 4'd11;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd12;
    localparam logic [OP_W-1:0] OP_XNOR = 4'd13;
    localparam logic [OP_W-1:0] OP_NOTA = 4'd14;
    localparam logic [OP_W-1:0] OP_NOTB = 4'd15;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic MD_MULT = 1'b0;
    localparam logic MD_DIV  = 1'b1;

endpackage

// File: rtl/ula_seq_muldiv.sv
// Iterative unit: shift-add multiplier or restoring divider, one step per cycle.
// done_c/q_c/ovf_c present the result of the final step on the edge that completes it.
module ula_seq_muldiv
    import ula_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done_c,
    output logic [WIDTH-1:0] q_c,
    output logic             ovf_c
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned ACC_W = 2 * WIDTH;

    logic             busy_q, busy_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [ACC_W-1:0] acc_q, acc_d;

    logic [WIDTH:0]   mul_sum;
    logic [ACC_W-1:0] mul_next;
    logic [WIDTH:0]   div_rem_sh;
    logic [WIDTH+1:0] div_diff;
    logic             div_borrow;
    logic [ACC_W-1:0] div_next;
    logic [ACC_W-1:0] step_next;

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum    = {1'b0, acc_q[ACC_W-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
        mul_next   = {mul_sum, acc_q[WIDTH-1:1]};
        div_rem_sh = acc_q[ACC_W-1:WIDTH-1];
        div_diff   = {1'b0, div_rem_sh} - {2'b00, b_q};
        div_borrow = div_diff[WIDTH+1];
        div_next   = {(div_borrow ? div_rem_sh[WIDTH-1:0] : div_diff[WIDTH-1:0]),
                      acc_q[WIDTH-2:0], ~div_borrow};
        step_next  = (mode_q == MD_DIV) ? div_next : mul_next;
        done_c     = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
        q_c        = step_next[WIDTH-1:0];
        ovf_c      = (mode_q == MD_MULT) && (|step_next[ACC_W-1:WIDTH]);
    end

    always_comb begin
        busy_d = busy_q;
        mode_d = mode_q;
        cnt_d  = cnt_q;
        b_d    = b_q;
        acc_d  = acc_q;
        if (start) begin
            busy_d = 1'b1;
            mode_d = mode;
            cnt_d  = '0;
            b_d    = b;
            acc_d  = {{WIDTH{1'b0}}, a};
        end else if (busy_q) begin
            acc_d = step_next;
            cnt_d = cnt_q + CNT_W'(1);
            if (done_c) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= 1'b0;
            mode_q <= MD_MULT;
            cnt_q  <= '0;
            b_q    <= '0;
            acc_q  <= '0;
        end else begin
            busy_q <= busy_d;
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
        end
    end

endmodule

// File: rtl/ula_seq.sv
// Handshaked WIDTH-bit ULA: single-cycle op mux, iterative MULT/DIV, registered result and flags.
// One operation per IDLE visit; the result is held in DONE until out_ready.
module ula_seq
    import ula_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             ov,
    output logic             zero,
    output logic             dz
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             ov_q, ov_d;
    logic             zero_q, zero_d;
    logic             dz_q, dz_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] sc_out;
    logic             sc_ov;
    logic             sc_dz;
    logic             is_iter;
    logic             md_start;
    logic             md_done_c;
    logic [WIDTH-1:0] md_q_c;
    logic             md_ovf_c;

    // Single-cycle result, computed straight from the presented operands
    always_comb begin
        sum     = {1'b0, A} + {1'b0, B};
        diff    = {1'b0, A} - {1'b0, B};
        sc_out  = '0;
        sc_ov   = 1'b0;
        sc_dz   = 1'b0;
        is_iter = (op == OP_MULT) || ((op == OP_DIV) && (B != '0));
        case (op)
            OP_ADD:  begin sc_out = sum[WIDTH-1:0];  sc_ov = sum[WIDTH];  end
            OP_SUB:  begin sc_out = diff[WIDTH-1:0]; sc_ov = diff[WIDTH]; end
            OP_DIV:  begin sc_out = '1; sc_dz = 1'b1; end
            OP_EQ:   sc_out = WIDTH'(A == B);
            OP_GT:   sc_out = WIDTH'(A > B);
            OP_LT:   sc_out = WIDTH'(A < B);
            OP_NE:   sc_out = WIDTH'(A != B);
            OP_AND:  sc_out = A & B;
            OP_NAND: sc_out = ~(A & B);
            OP_OR:   sc_out = A | B;
            OP_NOR:  sc_out = ~(A | B);
            OP_XOR:  sc_out = A ^ B;
            OP_XNOR: sc_out = ~(A ^ B);
            OP_NOTA: sc_out = ~A;
            OP_NOTB: sc_out = ~B;
            default: sc_out = '0;
        endcase
    end

    ula_seq_muldiv #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .mode   ((op == OP_DIV) ? MD_DIV : MD_MULT),
        .a      (A),
        .b      (B),
        .done_c (md_done_c),
        .q_c    (md_q_c),
        .ovf_c  (md_ovf_c)
    );

    // Next state and registered outputs
    always_comb begin
        state_d     = state_q;
        out_d       = out_q;
        ov_d        = ov_q;
        zero_d      = zero_q;
        dz_d        = dz_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        md_start    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    in_ready_d = 1'b0;
                    if (is_iter) begin
                        md_start = 1'b1;
                        state_d  = S_BUSY;
                    end else begin
                        state_d     = S_DONE;
                        out_d       = sc_out;
                        ov_d        = sc_ov;
                        dz_d        = sc_dz;
                        zero_d      = (sc_out == '0);
                        out_valid_d = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                if (md_done_c) begin
                    state_d     = S_DONE;
                    out_d       = md_q_c;
                    ov_d        = md_ovf_c;
                    dz_d        = 1'b0;
                    zero_d      = (md_q_c == '0);
                    out_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d     = S_IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_q       <= '0;
            ov_q        <= 1'b0;
            zero_q      <= 1'b0;
            dz_q        <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            ov_q        <= ov_d;
            zero_q      <= zero_d;
            dz_q        <= dz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out       = out_q;
    assign ov        = ov_q;
    assign zero      = zero_q;
    assign dz        = dz_q;

endmodule
